// File: rtl/riscv_pkg.sv
// Shared definitions for the five-stage RISC-V core: datapath width,
// ALU operation encodings, forwarding selects and writeback selects.
package riscv_pkg;

    localparam int XLEN = 32;

    // ALU operations driven on ALUControl
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback result selects
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/id_ex_stage_forward.sv
// EX-stage hazard detection: picks where each ALU operand comes from.
// The Memory stage is the youngest producer, so it wins over Writeback.
// x0 is hardwired to zero and is never forwarded.
module forward_unit (
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);
    import riscv_pkg::*;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Per-operand forward selects, evaluated every cycle (including stalls)
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand selection. Holds the decoded
// instruction for one cycle, inserts bubbles on flush, holds on stall, and
// feeds the ALU with forwarded operands from the Memory/Writeback stages.
module id_ex_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [3:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [1:0]      ResultSrcD,
    input  logic            ValidD,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ValidE,
    output logic [1:0]      ResultSrcE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE
);
    import riscv_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [1:0]      result_src;
        logic            valid;
    } ex_regs_t;

    ex_regs_t ex_q;
    ex_regs_t ex_d;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf,
        input logic [XLEN-1:0] wb,
        input logic [XLEN-1:0] mem
    );
        logic [XLEN-1:0] v;
        case (sel)
            FWD_WB:  v = wb;
            FWD_MEM: v = mem;
            default: v = rf;   // 2'b11 is never produced; fall back to RF
        endcase
        return v;
    endfunction

    // Next-state for the E bank: flush beats stall, stall beats load
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d          = '0;
            ex_d.alu_ctrl = ALU_ADD;
        end else if (!StallE) begin
            ex_d.rd1        = RD1D;
            ex_d.rd2        = RD2D;
            ex_d.imm        = ImmExtD;
            ex_d.pc         = PCD;
            ex_d.pc4        = PCPlus4D;
            ex_d.rs1        = Rs1D;
            ex_d.rs2        = Rs2D;
            ex_d.rd         = RdD;
            ex_d.alu_ctrl   = ALUControlD;
            ex_d.alu_src    = ALUSrcD;
            ex_d.reg_write  = RegWriteD;
            ex_d.mem_write  = MemWriteD;
            ex_d.jump       = JumpD;
            ex_d.branch     = BranchD;
            ex_d.result_src = ResultSrcD;
            ex_d.valid      = ValidD;
        end
    end

    // E register bank; reset loads the same all-zero bubble as a flush
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    forward_unit u_forward (
        .Rs1E      (ex_q.rs1),
        .Rs2E      (ex_q.rs2),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // Operand muxes to the ALU, same cycle as the forward decision
    always_comb begin
        fwd_a = fwd_mux(ForwardAE, ex_q.rd1, ResultW, ALUResultM);
        fwd_b = fwd_mux(ForwardBE, ex_q.rd2, ResultW, ALUResultM);
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign ALUControlE = ex_q.alu_ctrl;
    assign ImmExtE     = ex_q.imm;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc4;
    assign RdE         = ex_q.rd;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ValidE      = ex_q.valid;
    assign ResultSrcE  = ex_q.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic, compared against a behavioural model of the E-stage contents.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            StallE, FlushE;
    logic [31:0]     RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic [3:0]      ALUControlD;
    logic            ALUSrcD, RegWriteD, MemWriteD, JumpD, BranchD, ValidD;
    logic [1:0]      ResultSrcD;
    logic [31:0]     ALUResultM, ResultW;
    logic [4:0]      RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic [31:0]     SrcAE, SrcBE, WriteDataE, ImmExtE, PCE, PCPlus4E;
    logic [3:0]      ALUControlE;
    logic [4:0]      RdE, Rs1E, Rs2E;
    logic            RegWriteE, MemWriteE, JumpE, BranchE, ValidE;
    logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ResultSrcD(ResultSrcD), .ValidD(ValidD),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ValidE(ValidE), .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
    );

    // Model of what the E stage should currently hold
    typedef struct {
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        alusrc, rw, mw, j, b, v;
        logic [1:0]  rsrc;
    } ex_model_t;

    ex_model_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_val(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b10) return ALUResultM;
        if (sel == 2'b01) return ResultW;
        return rf;
    endfunction

    task automatic check_all();
        logic [1:0]  fa, fb;
        logic [31:0] a, bv;
        fa = model_sel(m.rs1);
        fb = model_sel(m.rs2);
        a  = model_val(fa, m.rd1);
        bv = model_val(fb, m.rd2);
        check("ForwardAE", 32'(ForwardAE), 32'(fa));
        check("ForwardBE", 32'(ForwardBE), 32'(fb));
        check("SrcAE", SrcAE, a);
        check("WriteDataE", WriteDataE, bv);
        check("SrcBE", SrcBE, m.alusrc ? m.imm : bv);
        check("ALUControlE", 32'(ALUControlE), 32'(m.alu));
        check("ImmExtE", ImmExtE, m.imm);
        check("PCE", PCE, m.pc);
        check("PCPlus4E", PCPlus4E, m.pc4);
        check("RdE", 32'(RdE), 32'(m.rd));
        check("Rs1E", 32'(Rs1E), 32'(m.rs1));
        check("Rs2E", 32'(Rs2E), 32'(m.rs2));
        check("ctrlE", {26'd0, RegWriteE, MemWriteE, JumpE, BranchE, ValidE, 1'b0},
              {26'd0, m.rw, m.mw, m.j, m.b, m.v, 1'b0});
        check("ResultSrcE", 32'(ResultSrcE), 32'(m.rsrc));
    endtask

    // One clock edge: update the model from the inputs seen at the edge
    task automatic tick();
        @(posedge clk);
        if (!reset_n || FlushE) begin
            m = '{default: '0};
        end else if (!StallE) begin
            m.rd1 = RD1D;  m.rd2 = RD2D;  m.imm = ImmExtD; m.pc = PCD; m.pc4 = PCPlus4D;
            m.rs1 = Rs1D;  m.rs2 = Rs2D;  m.rd = RdD;      m.alu = ALUControlD;
            m.alusrc = ALUSrcD; m.rw = RegWriteD; m.mw = MemWriteD;
            m.j = JumpD; m.b = BranchD; m.v = ValidD; m.rsrc = ResultSrcD;
        end
        #1;
        check_all();
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic rand_d();
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
        PCD = $urandom; PCPlus4D = PCD + 32'd4;
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        RdD = 5'($urandom); ALUControlD = 4'($urandom);
        ALUSrcD = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
        JumpD = 1'($urandom); BranchD = 1'($urandom); ValidD = 1'($urandom);
        ResultSrcD = 2'($urandom);
    endtask

    task automatic rand_mw();
        ALUResultM = $urandom; ResultW = $urandom;
        RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    endtask

    task automatic quiet_mw();
        RegWriteM = 1'b0; RegWriteW = 1'b0; RdM = 5'd0; RdW = 5'd0;
        ALUResultM = 32'h0; ResultW = 32'h0;
    endtask

    initial begin
        m = '{default: '0};
        StallE = 1'b0; FlushE = 1'b0;
        rand_d();
        RegWriteD = 1'b1; ValidD = 1'b1; RdD = 5'd9;
        quiet_mw();

        // Reset with live D inputs -> all zero bubble
        reset_n = 1'b0;
        tick();
        check("reset ValidE", 32'(ValidE), 32'd0);
        check("reset SrcAE", SrcAE, 32'd0);
        check("reset SrcBE", SrcBE, 32'd0);
        reset_n = 1'b1;

        // Register pass-through
        RD1D = 32'd5; RD2D = 32'd3; ALUSrcD = 1'b0; ALUControlD = ALU_ADD;
        Rs1D = 5'd1; Rs2D = 5'd2; ImmExtD = 32'h10;
        tick();
        check("pass SrcAE", SrcAE, 32'd5);
        check("pass SrcBE", SrcBE, 32'd3);
        ALUSrcD = 1'b1;
        tick();
        check("imm SrcBE", SrcBE, 32'h10);
        check("imm WriteDataE", WriteDataE, 32'd3);

        // Forward priority: Memory over Writeback
        Rs1D = 5'd7; RD1D = 32'h11;
        tick();
        RdM = 5'd7; RegWriteM = 1'b1; ALUResultM = 32'hAA;
        RdW = 5'd7; RegWriteW = 1'b1; ResultW = 32'hBB;
        settle();
        check("prio ForwardAE", 32'(ForwardAE), 32'd2);
        check("prio SrcAE", SrcAE, 32'hAA);
        RegWriteM = 1'b0;
        settle();
        check("wb ForwardAE", 32'(ForwardAE), 32'd1);
        check("wb SrcAE", SrcAE, 32'hBB);

        // x0 is never forwarded
        quiet_mw();
        Rs2D = 5'd0; RD2D = 32'h1234; ALUSrcD = 1'b0;
        tick();
        RdM = 5'd0; RegWriteM = 1'b1; ALUResultM = 32'hFF;
        settle();
        check("x0 ForwardBE", 32'(ForwardBE), 32'd0);
        check("x0 WriteDataE", WriteDataE, 32'h1234);
        quiet_mw();

        // Stall holds instruction A for two edges
        rand_d(); RdD = 5'd21; PCD = 32'hA000;
        tick();
        StallE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_d();
            tick();
        end
        check("stall RdE", 32'(RdE), 32'd21);
        check("stall PCE", PCE, 32'hA000);
        StallE = 1'b0;
        rand_d(); RdD = 5'd22;
        tick();
        check("release RdE", 32'(RdE), 32'd22);

        // Flush wins over stall
        rand_d(); RegWriteD = 1'b1; ValidD = 1'b1; RdD = 5'd9;
        tick();
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        check("flush RegWriteE", 32'(RegWriteE), 32'd0);
        check("flush RdE", 32'(RdE), 32'd0);
        check("flush ValidE", 32'(ValidE), 32'd0);
        FlushE = 1'b0; StallE = 1'b0;

        // Reset asserted while stalled still loads a bubble
        rand_d(); ValidD = 1'b1;
        tick();
        StallE = 1'b1; reset_n = 1'b0;
        tick();
        check("rst-stall ValidE", 32'(ValidE), 32'd0);
        reset_n = 1'b1; StallE = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_d();
            rand_mw();
            StallE  = ($urandom_range(0, 3) == 0);
            FlushE  = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 49) != 0);
            tick();
            rand_mw();
            settle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and execute-stage operand selection for the five-stage RISC-V core. Captures decoded operands and control from Decode, resolves EX-stage data hazards by forwarding from Memory and Writeback, and drives `SrcA`, `SrcB` and `ALUControl` of the ALU directly. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `XLEN`, 32, datapath width
- `clk` input 1 system clock, rising edge
- `reset_n` input 1 synchronous, active-low reset
- `StallE` input 1 hold all E registers this edge
- `FlushE` input 1 load a bubble this edge
- `RD1D`, `RD2D` input XLEN register-file read data
- `ImmExtD`, `PCD`, `PCPlus4D` input XLEN immediate, PC, PC+4
- `Rs1D`, `Rs2D`, `RdD` input 5 register indices
- `ALUControlD` input 4 ALU operation
- `ALUSrcD` input 1 0 = register, 1 = immediate for SrcB
- `RegWriteD`, `MemWriteD`, `JumpD`, `BranchD` input 1 control
- `ResultSrcD` input 2 writeback select
- `ValidD` input 1 instruction valid
- `ALUResultM` input XLEN forward source, Memory stage
- `RdM` input 5; `RegWriteM` input 1
- `ResultW` input XLEN forward source, Writeback stage
- `RdW` input 5; `RegWriteW` input 1
- `SrcAE`, `SrcBE` output XLEN to ALU `SrcA` / `SrcB`
- `ALUControlE` output 4 to ALU `ALUControl`
- `WriteDataE` output XLEN forwarded rs2 (store data)
- `ImmExtE`, `PCE`, `PCPlus4E` output XLEN registered
- `RdE`, `Rs1E`, `Rs2E` output 5 registered (to hazard unit)
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ValidE` output 1 registered
- `ResultSrcE` output 2 registered
- `ForwardAE`, `ForwardBE` output 2 current forward selects (hazard unit / debug)

## Operation
- Register update priority at each rising edge: `reset_n`=0 > `FlushE`=1 > `StallE`=1 > load from D.
- Reset and flush: every registered field loads 0 (bubble: `RegWriteE`=`MemWriteE`=`JumpE`=`BranchE`=`ValidE`=0, `ALUControlE`=ADD, `RdE`=0).
- Stall: every registered field holds; forwarding still evaluates against current M/W inputs.
- Forward select A (B identical with `Rs2E`): 2'b10 if `RegWriteM` && `RdM`!=0 && `RdM`==`Rs1E`; else 2'b01 if `RegWriteW` && `RdW`!=0 && `RdW`==`Rs1E`; else 2'b00. Memory stage wins when both match.
- Forwarded A = {00: RD1E, 01: ResultW, 10: ALUResultM}; 2'b11 never produced, treated as 00.
- `SrcAE` = forwarded A. `WriteDataE` = forwarded B. `SrcBE` = `ALUSrcE` ? `ImmExtE` : forwarded B.
- x0 never forwarded; `Rs1E`=0 always selects RD1E.
- No arithmetic in this block; all widths pass through unchanged.

## Timing
- D-to-E latency: 1 cycle; values presented at edge N appear on E outputs after edge N.
- `SrcAE`/`SrcBE`/`WriteDataE`/`ForwardAE`/`ForwardBE` are combinational from E registers and M/W inputs, same cycle; no added latency.
- Simultaneous `FlushE` and `StallE`: flush wins.
- Reset asserted mid-stall: bubble loaded at next edge regardless of `StallE`.
- After reset, all registered outputs 0; `SrcAE`=0, `SrcBE`=0 unless forwarding inputs active with `Rs`=0 (never, x0 excluded).

## Structure
- Shared package `riscv_pkg`: ALU op encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101, XOR 0111, SRL 1001, SLL 1010, SLTU 1011), forward-select constants (FWD_RF 00, FWD_WB 01, FWD_MEM 10), `ResultSrc` encodings, XLEN.
- One sub-module: `forward_unit` (combinational; Rs1E/Rs2E, RdM/RdW, RegWriteM/W -> ForwardAE/ForwardBE). Register bank and muxes in `id_ex_stage`.

## Test plan
- Reset: hold `reset_n`=0 one edge with nonzero D inputs -> all E outputs 0, `ValidE`=0.
- Pass-through: RD1D=5, RD2D=3, ALUSrcD=0, ALUControlD=ADD, no matches -> next cycle SrcAE=5, SrcBE=3, ALUControlE=0000; with ALUSrcD=1, ImmExtD=0x10 -> SrcBE=0x10, WriteDataE=3.
- Forward priority: Rs1E=7, RdM=7/RegWriteM=1/ALUResultM=0xAA, RdW=7/RegWriteW=1/ResultW=0xBB -> ForwardAE=10, SrcAE=0xAA; drop RegWriteM -> ForwardAE=01, SrcAE=0xBB.
- x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF -> ForwardBE=00, WriteDataE=RD2E.
- Stall: load instr A, assert StallE two cycles while D changes -> E outputs stay A; release -> next D loaded.
- Flush vs stall: StallE=1 and FlushE=1 same edge with RegWriteE=1 held -> RegWriteE=0, RdE=0, ValidE=0.
